// File: rtl/axi_cmd_fifo_pkg.sv
// axi_cmd_fifo_pkg: shared mode encodings and sizing helper for the command FIFO
package axi_cmd_fifo_pkg;
  typedef enum int {OUT_FWFT = 0, OUT_REG = 1} out_mode_e;
  typedef enum int {ERR_STICKY = 0, ERR_PULSE = 1} err_mode_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/axi_cmd_fifo_if.sv
// axi_cmd_fifo_if: push/pop requests, write/read data and status flags of the command FIFO
interface axi_cmd_fifo_if #(parameter int WIDTH = 8);
  logic             push_req_n;
  logic             pop_req_n;
  logic [WIDTH-1:0] data_in;
  logic             empty;
  logic             almost_empty;
  logic             half_full;
  logic             almost_full;
  logic             full;
  logic             error;
  logic [WIDTH-1:0] data_out;
  modport master (output push_req_n, pop_req_n, data_in,
                  input empty, almost_empty, half_full, almost_full, full, error, data_out);
  modport slave  (input push_req_n, pop_req_n, data_in,
                  output empty, almost_empty, half_full, almost_full, full, error, data_out);
endinterface

// File: rtl/axi_cmd_fifo_ram.sv
// axi_cmd_fifo_ram: DEPTH x WIDTH register array, one write port, one asynchronous read port
module axi_cmd_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/axi_cmd_fifo.sv
// axi_cmd_fifo: parametrised single-clock command FIFO with FWFT/registered output and sticky/pulsed error
// Optional output word_count enabled by defining AXI_CMD_FIFO_WORD_COUNT_EN.
module axi_cmd_fifo
  import axi_cmd_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AE_LEVEL = 1,
  parameter int AF_LEVEL = 1,
  parameter int OUT_MODE = 0,
  parameter int ERR_MODE = 0
) (
  input logic clk,
  input logic rst_n,
  axi_cmd_fifo_if.slave f
`ifdef AXI_CMD_FIFO_WORD_COUNT_EN
  , output logic [cnt_w(DEPTH)-1:0] word_count
`endif
);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] HF_C = CNT_W'((DEPTH + 1) / 2);
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(DEPTH - AF_LEVEL);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  if (DEPTH < 2 || AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1 || AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_param
    $error("axi_cmd_fifo: illegal DEPTH/AE_LEVEL/AF_LEVEL");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rdata, dreg;
  logic             err, pop_ok, push_ok, ovf, unf;

  assign pop_ok  = !f.pop_req_n && !f.empty;
  assign push_ok = !f.push_req_n && (!f.full || pop_ok);
  assign ovf     = !f.push_req_n && f.full && !pop_ok;
  assign unf     = !f.pop_req_n && f.empty;

  axi_cmd_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PTR_W)) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (f.data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
      dreg   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr == PTR_LAST ? '0 : wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr == PTR_LAST ? '0 : rd_ptr + PTR_W'(1);
      if (push_ok != pop_ok) count <= push_ok ? count + CNT_W'(1) : count - CNT_W'(1);
      err <= ERR_MODE == ERR_PULSE ? (ovf | unf) : (err | ovf | unf);
      if (pop_ok) dreg <= rdata;
    end

  assign f.empty        = count == '0;
  assign f.almost_empty = count <= AE_C;
  assign f.half_full    = count >= HF_C;
  assign f.almost_full  = count >= AF_C;
  assign f.full         = count == FULL_C;
  assign f.error        = err;
  // Empty FWFT output is masked so reset presents zero despite the unreset array
  assign f.data_out     = OUT_MODE == OUT_REG ? dreg : (f.empty ? '0 : rdata);
`ifdef AXI_CMD_FIFO_WORD_COUNT_EN
  assign word_count = count;
`endif
endmodule

// File: tb/tb_axi_cmd_fifo.sv
// tb_axi_cmd_fifo: three FIFO configurations driven in lockstep and checked against a shift-array model
module tb_axi_cmd_fifo;
  import axi_cmd_fifo_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_cmd_fifo_if #(.WIDTH(8)) i0 ();
  axi_cmd_fifo_if #(.WIDTH(8)) i1 ();
  axi_cmd_fifo_if #(.WIDTH(8)) i2 ();

`ifdef AXI_CMD_FIFO_WORD_COUNT_EN
  logic [2:0] wc0, wc1;
  logic [1:0] wc2;
`endif

  axi_cmd_fifo #(.WIDTH(8), .DEPTH(4), .AE_LEVEL(1), .AF_LEVEL(1), .OUT_MODE(0), .ERR_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .f(i0)
`ifdef AXI_CMD_FIFO_WORD_COUNT_EN
    , .word_count(wc0)
`endif
  );
  axi_cmd_fifo #(.WIDTH(8), .DEPTH(5), .AE_LEVEL(2), .AF_LEVEL(2), .OUT_MODE(0), .ERR_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .f(i1)
`ifdef AXI_CMD_FIFO_WORD_COUNT_EN
    , .word_count(wc1)
`endif
  );
  axi_cmd_fifo #(.WIDTH(8), .DEPTH(3), .AE_LEVEL(1), .AF_LEVEL(1), .OUT_MODE(1), .ERR_MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .f(i2)
`ifdef AXI_CMD_FIFO_WORD_COUNT_EN
    , .word_count(wc2)
`endif
  );

  logic [5:0] o_flg [3];
  logic [7:0] o_dout [3];
  int         o_wc [3];
  assign o_flg[0] = {i0.empty, i0.almost_empty, i0.half_full, i0.almost_full, i0.full, i0.error};
  assign o_flg[1] = {i1.empty, i1.almost_empty, i1.half_full, i1.almost_full, i1.full, i1.error};
  assign o_flg[2] = {i2.empty, i2.almost_empty, i2.half_full, i2.almost_full, i2.full, i2.error};
  assign o_dout[0] = i0.data_out;
  assign o_dout[1] = i1.data_out;
  assign o_dout[2] = i2.data_out;
`ifdef AXI_CMD_FIFO_WORD_COUNT_EN
  assign o_wc[0] = int'(wc0);
  assign o_wc[1] = int'(wc1);
  assign o_wc[2] = int'(wc2);
`else
  assign o_wc[0] = 0;
  assign o_wc[1] = 0;
  assign o_wc[2] = 0;
`endif

  int dep [3] = '{4, 5, 3};
  int ae  [3] = '{1, 2, 1};
  int af  [3] = '{1, 2, 1};
  int om  [3] = '{0, 0, 1};
  int em  [3] = '{0, 1, 0};

  int         n  [3];
  logic [7:0] qd [3][8];
  bit         me [3];
  logic [7:0] md [3];
  int nchk = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rn, input bit ps, input bit pp, input logic [7:0] d);
    for (int k = 0; k < 3; k++) begin
      if (!rn) begin
        n[k] = 0;
        me[k] = 1'b0;
        md[k] = 8'h00;
      end else begin
        bit pok, wok, ovf, unf;
        pok = pp && n[k] > 0;
        unf = pp && n[k] == 0;
        wok = ps && (n[k] < dep[k] || pok);
        ovf = ps && !wok;
        if (pok) begin
          if (om[k] == 1) md[k] = qd[k][0];
          for (int i = 0; i < 7; i++) qd[k][i] = qd[k][i+1];
          n[k]--;
        end
        if (wok) begin
          qd[k][n[k]] = d;
          n[k]++;
        end
        me[k] = em[k] == 1 ? (ovf || unf) : (me[k] || ovf || unf);
      end
    end
  endtask

  task automatic step(input bit rn, input bit ps, input bit pp, input logic [7:0] d);
    rst_n = rn;
    i0.push_req_n = !ps; i1.push_req_n = !ps; i2.push_req_n = !ps;
    i0.pop_req_n  = !pp; i1.pop_req_n  = !pp; i2.pop_req_n  = !pp;
    i0.data_in = d; i1.data_in = d; i2.data_in = d;
    @(posedge clk);
    model(rn, ps, pp, d);
    #1;
    for (int k = 0; k < 3; k++) begin
      logic [5:0] ef;
      ef = {n[k] == 0, n[k] <= ae[k], n[k] >= (dep[k] + 1) / 2, n[k] >= dep[k] - af[k], n[k] == dep[k], me[k]};
      chk($sformatf("flags%0d", k), 32'(o_flg[k]), 32'(ef));
      if (om[k] == 1) chk($sformatf("dout_reg%0d", k), 32'(o_dout[k]), 32'(md[k]));
      else if (n[k] > 0) chk($sformatf("dout_fwft%0d", k), 32'(o_dout[k]), 32'(qd[k][0]));
`ifdef AXI_CMD_FIFO_WORD_COUNT_EN
      chk($sformatf("word_count%0d", k), 32'(o_wc[k]), 32'(n[k]));
      nchk++;
      assert (o_wc[k] <= dep[k]) else begin
        fails++;
        $error("FAIL wc_bound%0d observed=%0d expected<=%0d", k, o_wc[k], dep[k]);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);
    chk("rst_dout0", 32'(i0.data_out), 32'h00);
    chk("rst_dout2", 32'(i2.data_out), 32'h00);
    chk("rst_flags0", 32'(o_flg[0]), 32'b110000);
    step(1, 1, 0, 8'h01);
    chk("fwft_first", 32'(i0.data_out), 32'h01);
    chk("one_empty", 32'(i0.empty), 32'h0);
    step(1, 1, 0, 8'h04);
    chk("two_ae", 32'(i0.almost_empty), 32'h0);
    chk("two_hf", 32'(i0.half_full), 32'h1);
    step(1, 0, 1, 8'h00);
    chk("pop_next", 32'(i0.data_out), 32'h04);
    step(1, 0, 1, 8'h00);
    chk("pop_empty", 32'(i0.empty), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 0, 8'(i));
      if (i == 3) chk("af_third", 32'(i0.almost_full), 32'h1);
    end
    chk("full_fourth", 32'(i0.full), 32'h1);
    step(1, 1, 0, 8'hEE);
    chk("ovf_err", 32'(i0.error), 32'h1);
    step(1, 0, 0, 8'h00);
    chk("err_sticky", 32'(i0.error), 32'h1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 8'h00);
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 8'(i));
    step(1, 1, 1, 8'h55);
    chk("pp_full", 32'(i0.full), 32'h1);
    chk("pp_head", 32'(i0.data_out), 32'h02);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 8'h00);
    step(1, 0, 1, 8'h00);
    chk("unf_pulse", 32'(i1.error), 32'h1);
    step(1, 0, 0, 8'h00);
    chk("unf_pulse_end", 32'(i1.error), 32'h0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'(8'h30 + i));
    step(0, 1, 0, 8'h77);
    chk("rst_mid", 32'(i1.empty), 32'h1);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 8'(8'hA0 + i));
      step(1, 0, 1, 8'h00);
      chk("reg_pop", 32'(i2.data_out), 32'(8'hA0 + i));
    end
    for (int i = 0; i < 500; i++)
      step(($urandom % 60) != 0, ($urandom % 3) != 0, ($urandom % 2) != 0, 8'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, fails);
    $finish;
  end
endmodule
